// File: rtl/dtc_vote_pkg.sv
// Shared types and sizing helpers for the decision-tree vote accumulator.
package dtc_vote_pkg;

    localparam int OUT_W_DEF = 18;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } dtc_vote_state_e;

    function automatic int cls_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/dtc_vote_counter_bank.sv
// Bank of per-class vote counters: parallel increment, synchronous clear,
// and one combinational indexed read port used by the argmax scan.
module dtc_vote_counter_bank
    import dtc_vote_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF,
    parameter int CNT_W = 5,
    parameter int CLS_W = cls_w(OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [OUT_W-1:0] inc_i,
    input  logic [CLS_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_o
);

    logic [CNT_W-1:0] cnt_q [OUT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < OUT_W; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < OUT_W; i++) begin
                if (inc_i[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Out-of-range indices read as zero.
    always_comb begin
        rd_cnt_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (rd_idx_i == CLS_W'(i)) rd_cnt_o = cnt_q[i];
        end
    end

endmodule

// File: rtl/dtc_vote_accumulator.sv
// Accumulates per-class votes over a window of leaf vectors, then scans for the argmax.
// Build option DTC_VOTE_FLUSH_EN adds a flush input that closes a non-empty window early.
module dtc_vote_accumulator
    import dtc_vote_pkg::*;
#(
    parameter int  OUT_W  = OUT_W_DEF,
    parameter int  WINDOW = 16,
    localparam int CNT_W  = cnt_w(WINDOW),
    localparam int CLS_W  = cls_w(OUT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] in_vec,
`ifdef DTC_VOTE_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie
);

    localparam int IDX_W = $clog2(OUT_W + 1);

    // A transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and held data stays stable until taken.
    dtc_vote_state_e  state_q, state_d;
    logic [CNT_W-1:0] samp_q, samp_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] max_cnt_q, max_cnt_d;
    logic [CLS_W-1:0] max_cls_q, max_cls_d;
    logic             max_tie_q, max_tie_d;
    logic [CLS_W-1:0] out_class_q, out_class_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_tie_q, out_tie_d;

    logic             accept;
    logic             win_end;
    logic             cnt_clr;
    logic [OUT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rd_cnt;

    assign accept = in_valid & in_ready;

    dtc_vote_counter_bank #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W),
        .CLS_W (CLS_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .rd_idx_i (CLS_W'(idx_q)),
        .rd_cnt_o (rd_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            samp_q      <= '0;
            idx_q       <= '0;
            max_cnt_q   <= '0;
            max_cls_q   <= '0;
            max_tie_q   <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_tie_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            idx_q       <= idx_d;
            max_cnt_q   <= max_cnt_d;
            max_cls_q   <= max_cls_d;
            max_tie_q   <= max_tie_d;
            out_class_q <= out_class_d;
            out_count_q <= out_count_d;
            out_tie_q   <= out_tie_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        idx_d       = idx_q;
        max_cnt_d   = max_cnt_q;
        max_cls_d   = max_cls_q;
        max_tie_d   = max_tie_q;
        out_class_d = out_class_q;
        out_count_d = out_count_q;
        out_tie_d   = out_tie_q;
        win_end     = 1'b0;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    samp_d = samp_q + CNT_W'(1);
                    if (samp_q == CNT_W'(WINDOW - 1)) win_end = 1'b1;
                end
`ifdef DTC_VOTE_FLUSH_EN
                if (flush && (samp_q != '0 || accept)) win_end = 1'b1;
`endif
                if (win_end) begin
                    state_d = SCAN;
                    samp_d  = '0;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                // Indices 0..OUT_W-1 compare one class each; index OUT_W latches the result.
                if (idx_q == IDX_W'(OUT_W)) begin
                    out_class_d = max_cls_q;
                    out_count_d = max_cnt_q;
                    out_tie_d   = max_tie_q;
                    state_d     = HOLD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == '0) begin
                        max_cnt_d = rd_cnt;
                        max_cls_d = '0;
                        max_tie_d = 1'b0;
                    end else if (rd_cnt > max_cnt_q) begin
                        max_cnt_d = rd_cnt;
                        max_cls_d = CLS_W'(idx_q);
                        max_tie_d = 1'b0;
                    end else if (rd_cnt == max_cnt_q) begin
                        max_tie_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
        cnt_clr   = (state_q == HOLD) && out_ready;
        cnt_inc   = accept ? in_vec : '0;
    end

    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_tie   = out_tie_q;

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
// Bench for dtc_vote_accumulator: window table, corner sequences, random windows vs. a vote model.
module tb_dtc_vote_accumulator;
  import dtc_vote_pkg::*;

  localparam int OUT_W  = 18;
  localparam int WINDOW = 16;
  localparam int CNT_W  = 5;
  localparam int CLS_W  = 5;
  localparam int LAT    = OUT_W + 1;
  localparam int RW     = CLS_W + CNT_W + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [CLS_W-1:0] out_class;
  logic [CNT_W-1:0] out_count;
  logic             out_tie;
`ifdef DTC_VOTE_FLUSH_EN
  logic             flush;
`endif

  int total = 0;
  int bad   = 0;
  int mcnt[OUT_W];
  int msamp = 0;
  logic [RW-1:0] exp_q[$];

  typedef struct {
    logic [OUT_W-1:0] va;
    logic [OUT_W-1:0] vb;
    logic [CLS_W-1:0] cls;
    logic [CNT_W-1:0] cnt;
    logic             tie;
    int               hold;
  } win_t;

  win_t tbl[7];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  dtc_vote_accumulator #(
    .OUT_W  (OUT_W),
    .WINDOW (WINDOW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
`ifdef DTC_VOTE_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_count (out_count),
    .out_tie   (out_tie)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // reference model: argmax with lowest index winning, tie if the maximum occurs twice or more
  function automatic logic [RW-1:0] model_result();
    int best = 0;
    int cls  = 0;
    int n    = 0;
    for (int i = 0; i < OUT_W; i++) begin
      if (mcnt[i] > best) begin
        best = mcnt[i];
        cls  = i;
      end
    end
    for (int i = 0; i < OUT_W; i++) if (mcnt[i] == best) n++;
    return {CLS_W'(cls), CNT_W'(best), (n > 1)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < OUT_W; i++) mcnt[i] = 0;
    msamp = 0;
  endtask

  task automatic model_close();
    exp_q.push_back(model_result());
    model_clear();
  endtask

  // driver tasks
  task automatic send(input logic [OUT_W-1:0] v);
    int guard = 0;
    in_valid = 1'b1;
    in_vec   = v;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic feed_vec(input logic [OUT_W-1:0] v);
    send(v);
    for (int i = 0; i < OUT_W; i++) if (v[i]) mcnt[i]++;
    msamp++;
    if (msamp == WINDOW) model_close();
  endtask

  // call right after the edge that closed the window
  task automatic collect(input int hold, output logic [RW-1:0] got);
    logic [RW-1:0] e;
    int k    = 0;
    int viol = 0;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!out_valid && in_ready) viol++;
    end while (!out_valid && k < 200);
    check("latency", k, LAT);
    check("in_ready_scan", viol, 0);
    check("out_class", int'(out_class), int'(e[RW-1 -: CLS_W]));
    check("out_count", int'(out_count), int'(e[CNT_W:1]));
    check("out_tie", int'(out_tie), int'(e[0]));
    got = {out_class, out_count, out_tie};
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_vec   = '1;
      @(posedge clk);
      #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_ready", int'(in_ready), 0);
      check("hold_class", int'(out_class), int'(e[RW-1 -: CLS_W]));
      check("hold_count", int'(out_count), int'(e[CNT_W:1]));
      check("hold_tie", int'(out_tie), int'(e[0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    logic [RW-1:0]    got;
    logic [OUT_W-1:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
`ifdef DTC_VOTE_FLUSH_EN
    flush     = 1'b0;
`endif
    model_clear();

    tbl[0] = '{18'h00001, 18'h00001, 5'd0,  5'd16, 1'b0, 0};
    tbl[1] = '{18'h20000, 18'h00002, 5'd1,  5'd8,  1'b1, 10};
    tbl[2] = '{18'h00000, 18'h00000, 5'd0,  5'd0,  1'b1, 2};
    tbl[3] = '{18'h00004, 18'h00004, 5'd2,  5'd16, 1'b0, 0};
    tbl[4] = '{18'h00003, 18'h00002, 5'd1,  5'd16, 1'b0, 3};
    tbl[5] = '{18'h3FFFF, 18'h3FFFF, 5'd0,  5'd16, 1'b1, 1};
    tbl[6] = '{18'h20000, 18'h20000, 5'd17, 5'd16, 1'b0, 0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_class", int'(out_class), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_tie", int'(out_tie), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven windows
    for (int w = 0; w < 7; w++) begin
      for (int s = 0; s < WINDOW; s++) feed_vec(s[0] ? tbl[w].vb : tbl[w].va);
      collect(tbl[w].hold, got);
      check($sformatf("tbl%0d_class", w), int'(got[RW-1 -: CLS_W]), int'(tbl[w].cls));
      check($sformatf("tbl%0d_count", w), int'(got[CNT_W:1]), int'(tbl[w].cnt));
      check($sformatf("tbl%0d_tie", w), int'(got[0]), int'(tbl[w].tie));
    end

    // reset while the scan is at index 7
    for (int s = 0; s < WINDOW; s++) feed_vec(18'h00010);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midscan_rst_valid", int'(out_valid), 0);
    check("midscan_rst_ready", int'(in_ready), 1);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", int'(out_valid), 0);
    check("post_rst_ready", int'(in_ready), 1);
    for (int s = 0; s < WINDOW; s++) feed_vec(18'h00004);
    collect(0, got);
    check("post_rst_class", int'(got[RW-1 -: CLS_W]), 2);
    check("post_rst_count", int'(got[CNT_W:1]), 16);

`ifdef DTC_VOTE_FLUSH_EN
    // flush with no samples must be ignored
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_empty_ready", int'(in_ready), 1);
    for (int s = 0; s < 3; s++) feed_vec(18'h00008);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_close();
    collect(0, got);
    check("flush_class", int'(got[RW-1 -: CLS_W]), 3);
    check("flush_count", int'(got[CNT_W:1]), 3);
    check("flush_tie", int'(got[0]), 0);
`endif

    // random windows with idle gaps and backpressure
    for (int w = 0; w < 6; w++) begin
      for (int s = 0; s < WINDOW; s++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        if ($urandom_range(0, 2) == 0) v = OUT_W'($urandom);
        else v = OUT_W'(1) << $urandom_range(0, OUT_W - 1);
        feed_vec(v);
      end
      collect($urandom_range(0, 3), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
